reg_scoreboard: RTL and testbench

- Register-dependency scoreboard and issue interlock for the decode stage.
- Tracks in-flight writes to each architectural register using per-register pending counters.
- Holds decode while any source it uses (rs0/rs1/rs2) has a write outstanding, or while execute cannot accept.
- Sits between decode (decoder, RF read) and execute; also observes the RF write-back port.

---
 rtl/reg_scoreboard_pkg.sv | 24 ++
 rtl/reg_scoreboard_if.sv | 33 +++
 rtl/reg_scoreboard_sb_entry.sv | 49 ++++
 rtl/reg_scoreboard.sv | 74 +++++++
 tb/tb_reg_scoreboard.sv | 135 +++++++++++++
 5 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared types and sizing for the register-dependency scoreboard.
package reg_scoreboard_pkg;

    localparam int REG_NUM = 32;
    localparam int REG_LOG = 5;
    localparam int CNT_W   = 2;
    localparam int PERF_W  = 32;

    typedef logic [REG_LOG-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [PERF_W-1:0]  perf_t;

    localparam reg_addr_t REG_ZERO = {REG_LOG{1'b0}};
    localparam cnt_t      CNT_ZERO = {CNT_W{1'b0}};
    localparam cnt_t      CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam cnt_t      CNT_MAX  = {CNT_W{1'b1}};

    // A source only blocks when it is really read, is not r0 and still has a write outstanding.
    function automatic logic src_hit(input logic used, input reg_addr_t addr,
                                     input logic [REG_NUM-1:0] nz);
        return used & (addr != REG_ZERO) & nz[addr];
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/execute/write-back signal bundle seen by the scoreboard.
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic               id_valid;
    reg_addr_t          rs0;
    reg_addr_t          rs1;
    reg_addr_t          rs2;
    logic [2:0]         rs_used;
    reg_addr_t          rd;
    logic               rd_we;
    logic               ex_ready;
    logic               wb_we;
    reg_addr_t          wb_addr;
    logic               flush;
    logic               id_ready;
    logic               issue;
    logic [REG_NUM-1:0] pending;
    logic               sb_err;
    perf_t              stall_cycles;

    modport master (
        output id_valid, rs0, rs1, rs2, rs_used, rd, rd_we, ex_ready,
               wb_we, wb_addr, flush,
        input  id_ready, issue, pending, sb_err, stall_cycles
    );

    modport slave (
        input  id_valid, rs0, rs1, rs2, rs_used, rd, rd_we, ex_ready,
               wb_we, wb_addr, flush,
        output id_ready, issue, pending, sb_err, stall_cycles
    );
endinterface

// File: rtl/reg_scoreboard_sb_entry.sv
// Pending-write counter for one architectural register.
module sb_entry
    import reg_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic nz,
    output logic full,
    output logic err
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    // Next count; a decrement of an empty counter holds at zero and flags an error.
    always_comb begin
        cnt_d = cnt_q;
        err   = 1'b0;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (inc && !dec) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (dec && !inc) begin
            if (cnt_q == CNT_ZERO) begin
                err = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nz   = (cnt_q != CNT_ZERO);
    assign full = (cnt_q == CNT_MAX);

endmodule

// File: rtl/reg_scoreboard.sv
// Issue interlock: holds decode on RAW hazards, counter saturation or busy execute.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    reg_scoreboard_if.slave sb
);

    logic [REG_NUM-1:0] nz_s;
    logic [REG_NUM-1:0] full_s;
    logic [REG_NUM-1:0] err_s;
    logic               raw_s;
    logic               sat_s;
    logic               sb_err_q;
    logic               sb_err_d;
    perf_t              stall_q;
    perf_t              stall_d;

    assign nz_s[0]   = 1'b0;
    assign full_s[0] = 1'b0;
    assign err_s[0]  = 1'b0;

    // r0 has no entry; it can never be pending, saturated or in error.
    for (genvar r = 1; r < REG_NUM; r++) begin : g_entry
        sb_entry u_entry (
            .clk  (clk),
            .rst  (rst),
            .inc  (sb.issue & sb.rd_we & (sb.rd == reg_addr_t'(r))),
            .dec  (sb.wb_we & (sb.wb_addr == reg_addr_t'(r))),
            .clr  (sb.flush),
            .nz   (nz_s[r]),
            .full (full_s[r]),
            .err  (err_s[r])
        );
    end

    // Same-cycle hazard decision; write-back is deliberately not bypassed.
    always_comb begin
        raw_s = src_hit(sb.rs_used[0], sb.rs0, nz_s)
              | src_hit(sb.rs_used[1], sb.rs1, nz_s)
              | src_hit(sb.rs_used[2], sb.rs2, nz_s);
        sat_s = sb.rd_we & (sb.rd != REG_ZERO) & full_s[sb.rd];
        sb.id_ready = sb.ex_ready & ~raw_s & ~sat_s & ~sb.flush;
        sb.issue    = sb.id_valid & sb.id_ready & ~sb.flush & rst;
    end

    // Sticky error and stall counter next values.
    always_comb begin
        sb_err_d = sb_err_q | (|err_s);
        stall_d  = stall_q;
        if (sb.id_valid && !sb.id_ready && !sb.flush) begin
            stall_d = stall_q + {{(PERF_W-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // Status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sb_err_q <= 1'b0;
            stall_q  <= {PERF_W{1'b0}};
        end else begin
            sb_err_q <= sb_err_d;
            stall_q  <= stall_d;
        end
    end

    assign sb.pending      = nz_s;
    assign sb.sb_err       = sb_err_q;
    assign sb.stall_cycles = stall_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomised and directed checks of reg_scoreboard against an array-based model.
module tb_reg_scoreboard;

    logic clk = 1'b0;
    logic rst = 1'b0;
    reg_scoreboard_if sbi ();

    reg_scoreboard dut (.clk(clk), .rst(rst), .sb(sbi.slave));

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          m_cnt [32];
    logic        m_err = 1'b0;
    logic [31:0] m_stall = 32'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive, check combinational outputs, clock, update model, check state.
    task automatic cyc(input logic v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [2:0] u, input logic [4:0] d,
                       input logic w, input logic er, input logic bw, input logic [4:0] ba,
                       input logic fl, input logic r);
        logic        raw, sat, rdy, iss;
        logic [4:0]  src [3];
        logic [31:0] pend;
        sbi.id_valid = v;  sbi.rs0 = a0; sbi.rs1 = a1; sbi.rs2 = a2; sbi.rs_used = u;
        sbi.rd = d; sbi.rd_we = w; sbi.ex_ready = er; sbi.wb_we = bw; sbi.wb_addr = ba;
        sbi.flush = fl; rst = r;
        src[0] = a0; src[1] = a1; src[2] = a2;
        raw = 1'b0;
        for (int i = 0; i < 3; i++)
            if (u[i] && src[i] != 5'd0 && m_cnt[src[i]] > 0) raw = 1'b1;
        sat = w && d != 5'd0 && m_cnt[d] == 3;
        rdy = er && !raw && !sat && !fl;
        iss = v && rdy && r;
        #1;
        chk("id_ready", {63'd0, sbi.id_ready}, {63'd0, rdy});
        chk("issue", {63'd0, sbi.issue}, {63'd0, iss});
        @(posedge clk);
        if (!r) begin
            for (int k = 0; k < 32; k++) m_cnt[k] = 0;
            m_err = 1'b0;
            m_stall = 32'd0;
        end else if (fl) begin
            for (int k = 0; k < 32; k++) m_cnt[k] = 0;
        end else begin
            for (int k = 1; k < 32; k++) begin
                logic inc, dec;
                inc = iss && w && d == 5'(k);
                dec = bw && ba == 5'(k);
                if (inc && !dec) m_cnt[k]++;
                else if (dec && !inc) begin
                    if (m_cnt[k] == 0) m_err = 1'b1;
                    else m_cnt[k]--;
                end
            end
            if (v && !rdy) m_stall = m_stall + 32'd1;
        end
        #1;
        for (int k = 0; k < 32; k++) pend[k] = (m_cnt[k] != 0);
        chk("pending", {32'd0, sbi.pending}, {32'd0, pend});
        chk("sb_err", {63'd0, sbi.sb_err}, {63'd0, m_err});
        chk("stall_cycles", {32'd0, sbi.stall_cycles}, {32'd0, m_stall});
    endtask

    // Plain writer of rd with no sources.
    task automatic wr(input logic [4:0] d);
        cyc(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, d, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    endtask

    // Write-back only, decode idle.
    task automatic wb(input logic [4:0] a, input logic fl);
        cyc(1'b0, 5'd0, 5'd0, 5'd0, 3'b000, 5'd0, 1'b0, 1'b1, 1'b1, a, fl, 1'b1);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) m_cnt[k] = 0;
        sbi.id_valid = 1'b0; sbi.rs0 = 5'd0; sbi.rs1 = 5'd0; sbi.rs2 = 5'd0;
        sbi.rs_used = 3'b000; sbi.rd = 5'd0; sbi.rd_we = 1'b0; sbi.ex_ready = 1'b0;
        sbi.wb_we = 1'b0; sbi.wb_addr = 5'd0; sbi.flush = 1'b0;
        @(posedge clk);
        #1;
        // Reset held with an instruction offered.
        repeat (2) cyc(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
        // RAW stall on r5, write-back not bypassed.
        wr(5'd5);
        repeat (3) cyc(1'b1, 5'd5, 5'd0, 5'd0, 3'b001, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc(1'b1, 5'd5, 5'd0, 5'd0, 3'b001, 5'd6, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
        cyc(1'b1, 5'd5, 5'd0, 5'd0, 3'b001, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        wb(5'd6, 1'b0);
        // Saturation on r7.
        repeat (3) wr(5'd7);
        wr(5'd7);
        cyc(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1);
        wr(5'd7);
        repeat (3) wb(5'd7, 1'b0);
        // Simultaneous issue and write-back on r9.
        wr(5'd9);
        cyc(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1);
        wb(5'd9, 1'b0);
        // r0 and unused sources never stall; rd=0 never pends.
        wr(5'd4);
        cyc(1'b1, 5'd0, 5'd0, 5'd0, 3'b010, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc(1'b1, 5'd1, 5'd2, 5'd4, 3'b011, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        cyc(1'b1, 5'd1, 5'd2, 5'd4, 3'b100, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
        wb(5'd4, 1'b0);
        // Flush ignores write-back; a later stray write-back sets the sticky error.
        wr(5'd3); wr(5'd3); wr(5'd8);
        cyc(1'b1, 5'd0, 5'd0, 5'd0, 3'b000, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1);
        wb(5'd3, 1'b0);
        repeat (3) wr(5'd2);
        // Randomised traffic over a small register window, with rare flush and reset.
        for (int n = 0; n < 800; n++) begin
            logic [4:0] ba;
            logic       bw;
            ba = 5'($urandom_range(0, 7));
            bw = ($urandom_range(0, 2) == 0) && (m_cnt[ba] > 0 || $urandom_range(0, 30) == 0);
            cyc(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 3'($urandom), 5'($urandom_range(0, 7)),
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), bw, ba,
                1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 150) != 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
